// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock synchronous FIFO with occupancy count,
// almost-full / almost-empty thresholds and sticky overflow / underflow flags.
//
// Optional feature macro: FIFO_FWFT_EN
//   undefined : registered-read mode. The popped word appears on data_out one
//               clock after an accepted read, with read_valid high for that
//               single cycle.
//   defined   : first-word-fall-through mode. data_out always shows the head
//               entry, read_valid = !empty, and read_en acknowledges the
//               presented word.
//
// Parameters:
//   WIDTH      data word width (>=1)
//   DEPTH      number of entries (>=2, any value, not only powers of two)
//   AFULL_THR  almost_full  when count >= AFULL_THR
//   AEMPTY_THR almost_empty when count <= AEMPTY_THR
//
// Ports:
//   clk, rst      clock (rising edge); asynchronous active-high reset
//   data_in       write data
//   write_en      write request
//   read_en       read request / acknowledge
//   clr_err       clears overflow and underflow (a same-cycle set wins)
//   data_out      read data
//   read_valid    data_out carries a valid word
//   empty, full, almost_empty, almost_full   registered status flags
//   count         current occupancy
//   overflow      sticky: a write was rejected since the last clear
//   underflow     sticky: a read was rejected since the last clear
// -----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write_en,
  input  logic                       read_en,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       read_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic             rd_acc, wr_acc;
  logic             ovf_set, unf_set;
  logic [WIDTH-1:0] dout_p1;
  logic             vld_p1;
`ifdef FIFO_FWFT_EN
  logic [WIDTH-1:0] head_nxt;
`endif

  // Stage p0: accept decisions and next-state computation
  always_comb begin
    // Reads are judged on the registered state only, so a same-cycle write
    // never makes an empty FIFO readable.
    rd_acc     = read_en && !empty;
    wr_acc     = write_en && (!full || rd_acc);
    ovf_set    = write_en && !wr_acc;
    unf_set    = read_en && !rd_acc;
    wr_ptr_nxt = wr_acc ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_nxt = rd_acc ? ptr_inc(rd_ptr) : rd_ptr;
    count_nxt  = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CW'(1);
    else if (rd_acc && !wr_acc) count_nxt = count - CW'(1);
  end

`ifdef FIFO_FWFT_EN
  // The next head is the word being written this cycle when the read pointer
  // lands on the write slot (FIFO empty, or draining its last entry).
  always_comb begin
    head_nxt = mem[rd_ptr_nxt];
    if (wr_acc && (rd_ptr_nxt == wr_ptr)) head_nxt = data_in;
  end
`endif

  // Storage is deliberately not reset; the !rst guard keeps writes out while
  // reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr] <= data_in;
  end

  // Stage p1: registered pointers, count, flags and output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_p1      <= '0;
      vld_p1       <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CW'(DEPTH));
      almost_empty <= (count_nxt <= CW'(AEMPTY_THR));
      almost_full  <= (count_nxt >= CW'(AFULL_THR));
      // Set has priority over clear.
      overflow     <= ovf_set || (overflow && !clr_err);
      underflow    <= unf_set || (underflow && !clr_err);
`ifdef FIFO_FWFT_EN
      vld_p1       <= (count_nxt != '0);
      if (count_nxt != '0) dout_p1 <= head_nxt;
`else
      vld_p1       <= rd_acc;
      if (rd_acc) dout_p1 <= mem[rd_ptr];
`endif
    end
  end

  assign data_out   = dout_p1;
  assign read_valid = vld_p1;

endmodule
